// File: rtl/mem_bus_arbiter_if.sv
// Shared data-memory bus handshake between pipeline/DMA side and arbiter.
// master drives the requests, slave (the arbiter) drives grant/stall.
interface mem_bus_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             hrq;
  logic             cpu_mem_busy;
  logic             hlda;
  logic             stall;
  logic             bus_sel;
  logic [CNT_W-1:0] dma_cycles;
  logic [1:0]       arb_state;

  modport master (
    output hrq, cpu_mem_busy,
    input  hlda, stall, bus_sel,
    input  dma_cycles, arb_state
  );

  modport slave (
    input  hrq, cpu_mem_busy,
    output hlda, stall, bus_sel,
    output dma_cycles, arb_state
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Data-memory bus arbiter: MIPS MEM stage vs 8237 DMA (HRQ/HLDA).
// Freezes the pipeline, drains, grants, then enforces a CPU window.
module mem_bus_arbiter #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CPU_WINDOW   = 4,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rst_n,
  mem_bus_arbiter_if.slave bus
);
  localparam int DW =
    DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int WW =
    CPU_WINDOW > 0 ? $clog2(CPU_WINDOW + 1) : 1;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DW-1:0]    drain_q;
  logic [WW-1:0]    win_q;
  logic [CNT_W-1:0] dma_q;
  logic             hlda;
  logic             stall;
  logic             sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CPU_OWN;
      drain_q <= '0;
      win_q   <= '0;
      dma_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        CPU_OWN: begin
          if (win_q != '0)
            win_q <= win_q - 1'b1;
          if (state_d == DRAIN)
            drain_q <= DW'(DRAIN_CYCLES);
        end
        DRAIN: begin
          if (drain_q != '0)
            drain_q <= drain_q - 1'b1;
          if (state_d == GRANT)
            dma_q <= '0;
        end
        GRANT: begin
          // count only cycles the DMA still holds the request
          if (bus.hrq && dma_q != '1)
            dma_q <= dma_q + 1'b1;
        end
        RELEASE: win_q <= WW'(CPU_WINDOW);
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CPU_OWN:
        if (bus.hrq && win_q == '0)
          state_d = DRAIN;
      DRAIN:
        if (!bus.hrq)
          state_d = RELEASE;
        else if (drain_q == '0 && !bus.cpu_mem_busy)
          state_d = GRANT;
      GRANT:
        if (!bus.hrq)
          state_d = RELEASE;
      RELEASE: state_d = CPU_OWN;
    endcase
  end

  always_comb begin
    stall = 1'b1;
    hlda  = 1'b0;
    sel   = 1'b0;
    unique case (state_q)
      CPU_OWN: stall = 1'b0;
      GRANT: begin
        hlda = 1'b1;
        sel  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.hlda       = hlda;
  assign bus.stall      = stall;
  assign bus.bus_sel    = sel;
  assign bus.dma_cycles = dma_q;
  assign bus.arb_state  = state_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: default params and an
// edge instance (no drain, no window, 4-bit counter).
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   ntests = 0;
  int   nfail  = 0;
  int   n;
  logic seen;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.CNT_W(16)) a0 ();
  mem_bus_arbiter_if #(.CNT_W(4))  a1 ();

  mem_bus_arbiter #(
    .DRAIN_CYCLES(2), .CPU_WINDOW(4), .CNT_W(16)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(a0.slave));

  mem_bus_arbiter #(
    .DRAIN_CYCLES(0), .CPU_WINDOW(0), .CNT_W(4)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(a1.slave));

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && a0.hlda)
      chk("inv0", 32'({a0.bus_sel, a0.stall}), 32'd3);
    if (rst_n && a1.hlda)
      chk("inv1", 32'({a1.bus_sel, a1.stall}), 32'd3);
  end

  initial begin
    rst_n = 1'b0;
    a0.hrq = 1'b0;
    a0.cpu_mem_busy = 1'b0;
    a1.hrq = 1'b0;
    a1.cpu_mem_busy = 1'b0;
    step();
    step();
    chk("rst_state", 32'(a0.arb_state), 32'd0);
    chk("rst_hlda", 32'(a0.hlda), 32'd0);
    chk("rst_stall", 32'(a0.stall), 32'd0);
    chk("rst_sel", 32'(a0.bus_sel), 32'd0);
    chk("rst_dma", 32'(a0.dma_cycles), 32'd0);
    rst_n = 1'b1;
    step();

    // basic grant
    a0.hrq = 1'b1;
    step();
    chk("b_stall", 32'(a0.stall), 32'd1);
    chk("b_hlda0", 32'(a0.hlda), 32'd0);
    chk("b_drain", 32'(a0.arb_state), 32'd1);
    step();
    step();
    chk("b_hlda_early", 32'(a0.hlda), 32'd0);
    step();
    chk("b_hlda", 32'(a0.hlda), 32'd1);
    chk("b_sel", 32'(a0.bus_sel), 32'd1);
    chk("b_grant", 32'(a0.arb_state), 32'd2);
    repeat (5) step();
    a0.hrq = 1'b0;
    step();
    chk("b_rel_hlda", 32'(a0.hlda), 32'd0);
    chk("b_rel_stall", 32'(a0.stall), 32'd1);
    chk("b_rel_sel", 32'(a0.bus_sel), 32'd0);
    chk("b_rel_state", 32'(a0.arb_state), 32'd3);
    chk("b_dma", 32'(a0.dma_cycles), 32'd5);
    step();
    chk("b_own_stall", 32'(a0.stall), 32'd0);
    chk("b_own_state", 32'(a0.arb_state), 32'd0);
    chk("b_dma_hold", 32'(a0.dma_cycles), 32'd5);
    repeat (6) step();

    // busy drain
    a0.hrq = 1'b1;
    a0.cpu_mem_busy = 1'b1;
    step();
    chk("d_stall", 32'(a0.stall), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      step();
      if (a0.hlda || !a0.stall)
        seen = 1'b1;
    end
    chk("d_hold", 32'(seen), 32'd0);
    a0.cpu_mem_busy = 1'b0;
    step();
    chk("d_hlda", 32'(a0.hlda), 32'd1);
    a0.hrq = 1'b0;
    step();
    step();
    repeat (6) step();

    // abort during drain
    a0.hrq = 1'b1;
    step();
    step();
    a0.hrq = 1'b0;
    step();
    chk("a_state", 32'(a0.arb_state), 32'd3);
    chk("a_hlda", 32'(a0.hlda), 32'd0);
    step();
    chk("a_own", 32'(a0.arb_state), 32'd0);

    // window after abort: 4 ignored cycles, honoured on the 5th
    a0.hrq = 1'b1;
    n = 0;
    while (a0.arb_state == 2'd0 && !a0.stall && n < 20) begin
      n++;
      step();
    end
    chk("w_abort_cnt", 32'(n), 32'd5);
    chk("w_abort_drain", 32'(a0.arb_state), 32'd1);
    repeat (3) step();
    chk("w_abort_hlda", 32'(a0.hlda), 32'd1);

    // window after a real grant
    a0.hrq = 1'b0;
    step();
    a0.hrq = 1'b1;
    step();
    chk("w_own", 32'(a0.arb_state), 32'd0);
    n = 0;
    while (a0.arb_state == 2'd0 && !a0.stall && n < 20) begin
      n++;
      step();
    end
    chk("w_grant_cnt", 32'(n), 32'd5);
    repeat (3) step();
    chk("w_grant_hlda", 32'(a0.hlda), 32'd1);

    // reset mid-grant with hrq held
    repeat (2) step();
    chk("r_dma_pre", 32'(a0.dma_cycles), 32'd2);
    rst_n = 1'b0;
    step();
    chk("r_hlda", 32'(a0.hlda), 32'd0);
    chk("r_stall", 32'(a0.stall), 32'd0);
    chk("r_sel", 32'(a0.bus_sel), 32'd0);
    chk("r_state", 32'(a0.arb_state), 32'd0);
    chk("r_dma", 32'(a0.dma_cycles), 32'd0);
    rst_n = 1'b1;
    step();
    chk("r_restall", 32'(a0.stall), 32'd1);
    step();
    step();
    chk("r_nohlda", 32'(a0.hlda), 32'd0);
    step();
    chk("r_rehlda", 32'(a0.hlda), 32'd1);
    a0.hrq = 1'b0;
    step();
    step();

    // zero drain, zero window, 4-bit saturation
    a1.hrq = 1'b1;
    step();
    chk("e_drain", 32'(a1.arb_state), 32'd1);
    chk("e_hlda0", 32'(a1.hlda), 32'd0);
    step();
    chk("e_hlda", 32'(a1.hlda), 32'd1);
    chk("e_dma0", 32'(a1.dma_cycles), 32'd0);
    repeat (3) step();
    chk("e_dma3", 32'(a1.dma_cycles), 32'd3);
    repeat (16) step();
    chk("e_sat", 32'(a1.dma_cycles), 32'd15);
    chk("e_grant", 32'(a1.arb_state), 32'd2);
    a1.hrq = 1'b0;
    step();
    chk("e_rel", 32'(a1.arb_state), 32'd3);
    chk("e_rel_hlda", 32'(a1.hlda), 32'd0);
    a1.hrq = 1'b1;
    step();
    chk("e_own", 32'(a1.arb_state), 32'd0);
    chk("e_own_stall", 32'(a1.stall), 32'd0);
    step();
    chk("e_drain2", 32'(a1.arb_state), 32'd1);
    step();
    chk("e_hlda2", 32'(a1.hlda), 32'd1);
    chk("e_dma_clr", 32'(a1.dma_cycles), 32'd0);
    a1.hrq = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
